ahb_reg_slave: RTL and testbench
================================

// Module: ahb_reg_slave
// PURPOSE
//  AHB-Lite responder: bank of NUM_REGS 32-bit read/write registers, the target end of the AHB master.
//  Accepts pipelined single/SEQ transfers, inserts WAIT_STATES wait cycles per transfer and returns
//  a two-cycle ERROR response for illegal accesses. Exposes registers and write strobes to user logic.
// PARAMETERS
//  NUM_REGS     16   number of 32-bit registers (2..256); word index = HADDR[2+IW-1:2], IW=clog2(NUM_REGS)
//  WAIT_STATES  0    HREADYOUT-low cycles inserted in every OKAY data phase (0..15)
//  RESET_VAL    0    32-bit reset value of every register
// PORTS
//  HCLK        in   1              bus clock, all logic on rising edge
//  HRESET      in   1              synchronous, active-high reset
//  HSEL        in   1              slave select (address phase)
//  HADDR       in   32             byte address
//  HTRANS      in   2              00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HWRITE      in   1              1 write, 0 read
//  HSIZE       in   3              only 3'b010 (word) legal
//  HBURST      in   3              ignored; bursts handled as individual beats
//  HPROT       in   4              ignored
//  HWDATA      in   32             write data (data phase)
//  HREADY      in   1              bus-level ready; transfers sampled only when high
//  HRDATA      out  32             read data
//  HREADYOUT   out  1              slave ready
//  HRESP       out  1              0 OKAY, 1 ERROR
//  regs_o      out  32*NUM_REGS    flat register contents, reg n at [32n+31:32n]
//  wr_pulse_o  out  NUM_REGS       1-cycle strobe, bit n high in cycle after reg n written
// BEHAVIOUR
//  Reset (HRESET=1 at edge): state IDLE, regs=RESET_VAL, HREADYOUT=1, HRESP=0, HRDATA=0, wr_pulse_o=0.
//   Reset mid-transfer aborts it; no register update.
//  Address phase accepted when HSEL & HREADY & HTRANS[1]; latch index, HWRITE, error flag.
//   IDLE/BUSY or HSEL=0 -> no data phase, OKAY, zero wait.
//  Error if HSIZE!=010, HADDR[1:0]!=0, or HADDR[31:2]>=NUM_REGS.
//  FSM states: IDLE, DATA, ERR1, ERR2.
//   IDLE: HREADYOUT=1,HRESP=0. Accept -> ERR1 if error, else DATA with cnt=WAIT_STATES.
//   DATA: HREADYOUT=(cnt==0), HRESP=0; cnt decrements while >0. When cnt==0 the phase completes:
//    write -> reg[idx]<=HWDATA at that edge, wr_pulse_o[idx]=1 next cycle; read -> HRDATA=reg[idx]
//    during that cycle (0 otherwise). Next: new accept -> DATA/ERR1, else IDLE.
//   ERR1: HREADYOUT=0,HRESP=1 -> ERR2. ERR2: HREADYOUT=1,HRESP=1; accepts new transfer like IDLE.
//  Errored transfers never modify registers nor pulse wr_pulse_o; HRDATA=0.
//  Latency: OKAY transfer data phase = WAIT_STATES+1 cycles; ERROR = 2 cycles.
//  Back-to-back: address phase of transfer N+1 overlaps completing data phase of N (zero bubbles).
//  Write then read same reg back-to-back: read returns newly written value.
//  HWDATA sampled only at completing DATA edge; earlier wait-cycle values ignored.
//  Address phases presented while HREADYOUT=0 are ignored (HREADY low); master must hold them.
// TESTING
//  WAIT_STATES=0: write 0xDEADBEEF @0x08, read @0x08 -> HRDATA=0xDEADBEEF, HRESP=0, wr_pulse_o[2] one cycle.
//  WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, data valid on 4th, regs unchanged.
//  Write @0x40 with NUM_REGS=16 -> HREADYOUT/HRESP = 0/1 then 1/1; no reg or wr_pulse_o change.
//  HSIZE=000 or HADDR=0x05 -> same two-cycle ERROR; following legal write completes OKAY.
//  Pipelined NONSEQ W@0x00=1, SEQ W@0x04=2, SEQ R@0x00 -> regs0=1, regs1=2, read returns 1, no idle gaps.
//  HRESET asserted during wait cycle of write 0x55 @0x0C -> reg3=RESET_VAL, HREADYOUT=1, HRESP=0 after reset.

Source files
------------

// File: rtl/ahb_reg_slave.sv
// AHB-Lite register-bank responder: NUM_REGS word registers,
// optional wait states, two-cycle ERROR for illegal accesses.
module ahb_reg_slave #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RESET_VAL   = '0
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [3:0]               HPROT,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic [31:0]              HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [IW-1:0] idx;
    logic          wr;
    logic [31:0]   regs [NUM_REGS];

    logic accept;
    logic addr_err;
    logic done;
    logic can_accept;

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign addr_err = (HSIZE != 3'b010)
                    | (HADDR[1:0] != 2'b00)
                    | (HADDR[31:2] >= 30'(NUM_REGS));
    assign done     = (state == S_DATA) && (cnt == 4'd0);
    assign can_accept = (state == S_IDLE)
                      | (state == S_ERR2)
                      | done;

    // BURST/PROT carry no meaning for a flat register bank
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            wr         <= 1'b0;
            HREADYOUT  <= 1'b1;
            HRESP      <= 1'b0;
            wr_pulse_o <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VAL;
        end else begin
            wr_pulse_o <= '0;
            if (done && wr) begin
                regs[idx]       <= HWDATA;
                wr_pulse_o[idx] <= 1'b1;
            end
            if (state == S_DATA && cnt != 4'd0) begin
                cnt       <= cnt - 4'd1;
                HREADYOUT <= (cnt == 4'd1);
            end else if (state == S_ERR1) begin
                state     <= S_ERR2;
                HREADYOUT <= 1'b1;
                HRESP     <= 1'b1;
            end else if (can_accept && accept) begin
                idx <= HADDR[IW+1:2];
                wr  <= HWRITE;
                if (addr_err) begin
                    state     <= S_ERR1;
                    HREADYOUT <= 1'b0;
                    HRESP     <= 1'b1;
                end else begin
                    state     <= S_DATA;
                    cnt       <= 4'(WAIT_STATES);
                    HREADYOUT <= (WAIT_STATES == 0);
                    HRESP     <= 1'b0;
                end
            end else begin
                state     <= S_IDLE;
                HREADYOUT <= 1'b1;
                HRESP     <= 1'b0;
            end
        end
    end

    // read data straight from the bank so a preceding write is visible
    assign HRDATA = (done && !wr) ? regs[idx] : '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Scoreboard bench for ahb_reg_slave: one instance with no wait
// states and one with three, driven over a shared bus.
module tb_ahb_reg_slave;

    localparam logic [31:0] RV0 = 32'h0000_0000;
    localparam logic [31:0] RV3 = 32'h0000_A5A5;
    localparam logic [2:0]  WD  = 3'b010;
    localparam logic [1:0]  NS  = 2'b10;
    localparam logic [1:0]  SQ  = 2'b11;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;

    logic [31:0]  rdata0, rdata3;
    logic         ro0, ro3, resp0, resp3;
    logic [511:0] regs0, regs3;
    logic [15:0]  pulse0, pulse3;

    bit tgt;
    logic sel0, sel3;
    assign sel0 = HSEL & !tgt;
    assign sel3 = HSEL & tgt;

    logic         m_ready, m_resp;
    logic [31:0]  m_rdata;
    logic [511:0] m_regs;
    logic [15:0]  m_pulse;
    assign m_ready = tgt ? ro3 : ro0;
    assign m_resp  = tgt ? resp3 : resp0;
    assign m_rdata = tgt ? rdata3 : rdata0;
    assign m_regs  = tgt ? regs3 : regs0;
    assign m_pulse = tgt ? pulse3 : pulse0;

    ahb_reg_slave #(
        .NUM_REGS(16), .WAIT_STATES(0), .RESET_VAL(RV0)
    ) u0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADY(ro0), .HRDATA(rdata0),
        .HREADYOUT(ro0), .HRESP(resp0), .regs_o(regs0),
        .wr_pulse_o(pulse0)
    );

    ahb_reg_slave #(
        .NUM_REGS(16), .WAIT_STATES(3), .RESET_VAL(RV3)
    ) u3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel3),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADY(ro3), .HRDATA(rdata3),
        .HREADYOUT(ro3), .HRESP(resp3), .regs_o(regs3),
        .wr_pulse_o(pulse3)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          idx;
        int          ws;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [2][16];
    logic [31:0] pend_wd;
    int          n_chk;
    int          n_pass;

    function automatic void chk(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h", nm, act, exp);
    endfunction

    // monitor: pops one expectation per completed data phase
    bit          dp;
    int          waits;
    logic        first_resp;
    logic [15:0] exp_pulse;
    exp_t        e;

    always @(negedge HCLK) begin
        if (HRESET) begin
            dp        = 1'b0;
            waits     = 0;
            exp_pulse = '0;
            q.delete();
        end else begin
            chk("wr_pulse", 32'(m_pulse), 32'(exp_pulse));
            exp_pulse = '0;
            if (!dp) begin
                chk("idle_rdy", 32'(m_ready), 32'd1);
                chk("idle_resp", 32'(m_resp), 32'd0);
                chk("idle_rdata", m_rdata, 32'd0);
            end else if (!m_ready) begin
                waits++;
                if (waits == 1) first_resp = m_resp;
            end else begin
                if (q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp", 32'(m_resp), 32'(e.err));
                    chk("waits", 32'(waits), 32'(e.ws));
                    if (e.err)
                        chk("err1_resp", 32'(first_resp), 32'd1);
                    chk("rdata", m_rdata, e.data);
                    if (!e.err && !e.rd)
                        exp_pulse = 16'd1 << e.idx;
                end
                waits = 0;
            end
        end
        if (!(dp && !m_ready))
            dp = !HRESET && HSEL && HTRANS[1] && m_ready;
    end

    task automatic wait_ready();
        int n = 0;
        forever begin
            @(negedge HCLK);
            HWDATA = m_ready ? pend_wd : ~pend_wd;
            if (m_ready) break;
            n++;
            if (n > 40) begin
                chk("timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic issue(input bit          w,
                         input logic [31:0] a,
                         input logic [2:0]  sz,
                         input logic [1:0]  tr,
                         input logic [31:0] wd);
        exp_t x;
        HSEL   = 1'b1;
        HADDR  = a;
        HTRANS = tr;
        HWRITE = w;
        HSIZE  = sz;
        wait_ready();
        @(posedge HCLK);
        #1;
        x.err = (sz != 3'b010) || (a[1:0] != 2'b00)
              || (a[31:2] >= 30'd16);
        x.rd  = !w;
        x.idx = int'(a[5:2]);
        x.ws  = x.err ? 1 : (tgt ? 3 : 0);
        if (!x.err && w) mdl[tgt][x.idx] = wd;
        x.data = (x.err || w) ? 32'd0 : mdl[tgt][x.idx];
        q.push_back(x);
        pend_wd = wd;
        HWDATA  = wd;
    endtask

    task automatic finish_dp();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        wait_ready();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_reg%0d", tag, i),
                m_regs[32*i +: 32], mdl[tgt][i]);
    endtask

    task automatic set_tgt(input bit t);
        tgt = t;
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        tgt     = 1'b0;
        HSEL    = 1'b0;
        HADDR   = '0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = WD;
        HBURST  = 3'b001;
        HPROT   = 4'b0011;
        HWDATA  = '0;
        pend_wd = '0;
        for (int i = 0; i < 16; i++) begin
            mdl[0][i] = RV0;
            mdl[1][i] = RV3;
        end

        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk_regs("rst0");
        set_tgt(1'b1);
        chk_regs("rst3");
        chk("rst3_rdy", 32'(m_ready), 32'd1);
        chk("rst3_resp", 32'(m_resp), 32'd0);
        set_tgt(1'b0);
        @(posedge HCLK);
        #1;

        issue(1'b1, 32'h08, WD, NS, 32'hDEAD_BEEF);
        issue(1'b0, 32'h08, WD, NS, 32'h0);
        finish_dp();
        chk_regs("wr08");

        issue(1'b1, 32'h40, WD, NS, 32'h1111_1111);
        finish_dp();
        chk_regs("oor");

        issue(1'b1, 32'h04, 3'b000, NS, 32'h2222_2222);
        issue(1'b1, 32'h05, WD, NS, 32'h3333_3333);
        issue(1'b1, 32'h0C, WD, NS, 32'h0000_1234);
        issue(1'b0, 32'h0C, WD, NS, 32'h0);
        finish_dp();
        chk_regs("szal");

        issue(1'b1, 32'h00, WD, NS, 32'h1);
        issue(1'b1, 32'h04, WD, SQ, 32'h2);
        issue(1'b0, 32'h00, WD, SQ, 32'h0);
        finish_dp();
        chk_regs("pipe");

        issue(1'b0, 32'h44, WD, NS, 32'h0);
        finish_dp();

        HSEL   = 1'b1;
        HADDR  = 32'h08;
        HWRITE = 1'b1;
        HTRANS = 2'b01;
        @(posedge HCLK);
        #1 HTRANS = 2'b00;
        @(posedge HCLK);
        #1 HSEL = 1'b0;
        @(posedge HCLK);
        #1;
        chk_regs("busy");

        set_tgt(1'b1);
        issue(1'b0, 32'h10, WD, NS, 32'h0);
        finish_dp();
        chk_regs("ws_rd");

        issue(1'b1, 32'h14, WD, NS, 32'hCAFE_F00D);
        issue(1'b0, 32'h14, WD, NS, 32'h0);
        finish_dp();
        chk_regs("ws_wr");

        issue(1'b1, 32'h40, WD, NS, 32'h7777_7777);
        issue(1'b0, 32'h14, WD, NS, 32'h0);
        finish_dp();
        chk_regs("ws_err");

        issue(1'b1, 32'h0C, WD, NS, 32'h55);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        @(negedge HCLK);
        chk("mid_wait", 32'(m_ready), 32'd0);
        @(posedge HCLK);
        #1 HRESET = 1'b1;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mdl[0][i] = RV0;
            mdl[1][i] = RV3;
        end
        @(negedge HCLK);
        chk("rst_rdy", 32'(m_ready), 32'd1);
        chk("rst_resp", 32'(m_resp), 32'd0);
        chk("rst_reg3", m_regs[96 +: 32], RV3);
        chk_regs("mid_rst3");
        set_tgt(1'b0);
        chk_regs("mid_rst0");

        repeat (2) @(negedge HCLK);
        chk("sb_left", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
